hdr_arbiter: RTL
================

Name: hdr_arbiter

Overview:
- Shares one header engine between two preprocessing requesters, A and B.
- Grants the engine header-atomically (soh..eoh) using round-robin arbitration.
- Drives the engine's word/strobe interface and honours its hReady backpressure.
- Keeps a tag FIFO of header owners so each engine result (valid pulse) can be routed back to its source.

Parameters:
- DATA_W, 32, header word width.
- TAG_DEPTH, 8, owner-tag FIFO depth; must be a power of 2 and at least 2.
- TAG_AW, 3, log2(TAG_DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A word valid.
- a_data  in  DATA_W  requester A word.
- a_flags  in  6  requester A strobes: [0]sa [1]da [2]sp_dp [3]prot [4]soh [5]eoh.
- a_ready  out  1  requester A word accepted this cycle.
- b_valid, b_data, b_flags, b_ready: same as the A ports, for requester B.
- data  out  DATA_W  word to header engine.
- sa, da, sp_dp, prot, soh, eoh  out  1 each  strobes to header engine.
- hReady  in  1  header engine can take a word.
- hValid  in  1  header engine result valid pulse.
- res_src  out  1  owner of the oldest outstanding result: 0=A, 1=B.
- res_src_vld  out  1  tag FIFO not empty.
- tag_full  out  1  tag FIFO full.
- drop  out  1  one-cycle error pulse: stray word discarded, or hValid seen while FIFO empty.

Behaviour:
- Reset (synchronous, active-high). All of the following are 0:
  - data and all six strobes;
  - a_ready, b_ready;
  - res_src, res_src_vld, drop.
  - Tag FIFO is empty and tag_full=0.
  - State = IDLE; round-robin pointer rr = A (A wins the next tie).
  - Reset mid-header abandons the header; no tag is pushed.
- States: IDLE, OWN_A, OWN_B.
- IDLE:
  - Candidates are requesters with valid=1 and flags[4]=1 (soh).
  - If a candidate exists and tag_full=0: grant the sole candidate, or rr on a tie; go to OWN_x next cycle.
  - The soh word is not consumed in the grant cycle: ready=0, so there is 1 cycle of arbitration latency.
  - A valid word without soh is discarded: ready=1 and drop=1 for that cycle. If both requesters have one, both are discarded.
  - tag_full=1: no grant; soh words wait with ready=0.
- OWN_x:
  - x_ready = hReady (combinational); the other requester's ready=0.
  - A transfer occurs when x_valid & x_ready.
  - On transfer, the next cycle has data=x_data and strobes=x_flags, held for exactly one cycle (latency 1).
  - With no transfer, all strobes are 0 next cycle; data holds its last value.
  - A soh word mid-header is forwarded unchanged and has no tag effect.
- Header end:
  - A transfer with flags[5]=1 (eoh) pushes tag x into the FIFO on the same edge.
  - Same edge: rr := other requester, state := IDLE.
  - A single word carrying both soh and eoh is a complete header.
- Tag FIFO:
  - res_src = FIFO head; res_src_vld = !empty; tag_full = (count==TAG_DEPTH).
  - Pop when hValid & !empty.
  - hValid while empty is ignored, with drop=1.
  - Push and pop in the same cycle both succeed; count is unchanged.
  - Pointers wrap modulo TAG_DEPTH; count is TAG_AW+1 bits.
  - Overflow cannot occur: a grant requires !tag_full and at most one header is open.

Optional Feature:
- Macro: HDR_ARB_STATS_EN.
- When defined, adds three output ports:
  - a_hdr_cnt  out  16  headers completed by A; +1 per eoh transfer; wraps 0xFFFF->0.
  - b_hdr_cnt  out  16  same, for B.
  - drop_cnt  out  8  +1 per cycle with drop=1; saturates at 0xFF.
- All three counters reset to 0.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- A sends 3-word header (soh/sa, da, sp_dp/prot/eoh), hReady=1:
  - State OWN_A one cycle after a_valid.
  - Engine strobes appear one cycle after each a_ready cycle.
  - res_src_vld=1 with res_src=0.
  - hValid pulse -> res_src_vld=0.
- A and B both raise soh in the same cycle after reset:
  - A is granted first.
  - After A's eoh, B is granted; b_ready stays 0 until then.
  - Next tie goes to A.
- hReady=0 for 4 cycles mid-header:
  - a_ready=0 and all strobes=0 during the stall.
  - Words resume in order with no loss or duplication.
- Push 8 single-word headers with no hValid:
  - tag_full=1.
  - A 9th soh waits with ready=0.
  - One hValid -> grant proceeds the next cycle.
- Stray a_valid without soh in IDLE:
  - a_ready=1 and drop=1; no strobes to the engine.
  - hValid while FIFO empty -> drop=1.
  - With HDR_ARB_STATS_EN defined, drop_cnt=2.
- Assert rst during OWN_B mid-header:
  - Next cycle: IDLE, all outputs 0, FIFO empty.
  - A subsequent A/B tie grants A.

Source files
------------

// File: rtl/hdr_arbiter_if.sv
// Requester, header-engine and result-routing signals of hdr_arbiter.
// HDR_ARB_STATS_EN adds the header/drop statistics counters.
interface hdr_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic [5:0]        a_flags;
  logic              a_ready;
  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic [5:0]        b_flags;
  logic              b_ready;
  logic [DATA_W-1:0] data;
  logic              sa;
  logic              da;
  logic              sp_dp;
  logic              prot;
  logic              soh;
  logic              eoh;
  logic              hReady;
  logic              hValid;
  logic              res_src;
  logic              res_src_vld;
  logic              tag_full;
  logic              drop;
`ifdef HDR_ARB_STATS_EN
  logic [15:0]       a_hdr_cnt;
  logic [15:0]       b_hdr_cnt;
  logic [7:0]        drop_cnt;
`endif

  // slave: the arbiter itself; master: requesters, engine and result consumer.
  modport slave (
    input  a_valid, a_data, a_flags, b_valid, b_data, b_flags, hReady, hValid,
`ifdef HDR_ARB_STATS_EN
    output a_hdr_cnt, b_hdr_cnt, drop_cnt,
`endif
    output a_ready, b_ready, data, sa, da, sp_dp, prot, soh, eoh,
    output res_src, res_src_vld, tag_full, drop
  );

  modport master (
    output a_valid, a_data, a_flags, b_valid, b_data, b_flags, hReady, hValid,
`ifdef HDR_ARB_STATS_EN
    input  a_hdr_cnt, b_hdr_cnt, drop_cnt,
`endif
    input  a_ready, b_ready, data, sa, da, sp_dp, prot, soh, eoh,
    input  res_src, res_src_vld, tag_full, drop
  );
endinterface

// File: rtl/hdr_arbiter.sv
// Header-atomic round-robin arbiter sharing one header engine between A and B,
// with an owner-tag FIFO for result routing. Optional stats: HDR_ARB_STATS_EN.
module hdr_arbiter #(
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 8,
  parameter int TAG_AW    = 3
) (
  input  logic         clk,
  input  logic         rst,
  hdr_arbiter_if.slave bus,
  output logic [1:0]   o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rr;
  logic                w_rr_nxt;
  logic [DATA_W-1:0]   r_data;
  logic [5:0]          r_flags;
  logic [TAG_DEPTH-1:0] r_tags;
  logic [TAG_AW-1:0]   r_wr_ptr;
  logic [TAG_AW-1:0]   r_rd_ptr;
  logic [TAG_AW:0]     r_count;

  logic                w_cand_a;
  logic                w_cand_b;
  logic                w_a_ready;
  logic                w_b_ready;
  logic                w_stray;
  logic                w_xfer;
  logic                w_xfer_src;
  logic [DATA_W-1:0]   w_xfer_data;
  logic [5:0]          w_xfer_flags;
  logic                w_push;
  logic                w_pop;
  logic                w_empty;
  logic                w_full;
  logic                w_drop;

  assign w_cand_a = bus.a_valid & bus.a_flags[4];
  assign w_cand_b = bus.b_valid & bus.b_flags[4];
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == (TAG_AW+1)'(TAG_DEPTH));
  assign w_pop    = bus.hValid & ~w_empty;

  // Handshake: a requester word moves when valid & ready are both high at a
  // rising edge; ready never depends on valid except for the IDLE stray-discard.
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_nxt     = r_rr;
    w_a_ready    = 1'b0;
    w_b_ready    = 1'b0;
    w_stray      = 1'b0;
    w_xfer       = 1'b0;
    w_xfer_src   = 1'b0;
    w_xfer_data  = '0;
    w_xfer_flags = '0;
    w_push       = 1'b0;
    case (r_state)
      IDLE: begin
        // soh words wait for a grant; anything else is outside a header and is discarded
        w_a_ready = bus.a_valid & ~bus.a_flags[4];
        w_b_ready = bus.b_valid & ~bus.b_flags[4];
        w_stray   = w_a_ready | w_b_ready;
        if ((w_cand_a | w_cand_b) && !w_full) begin
          if (w_cand_a && w_cand_b) w_state_nxt = r_rr ? OWN_B : OWN_A;
          else                      w_state_nxt = w_cand_b ? OWN_B : OWN_A;
        end
      end
      OWN_A: begin
        w_a_ready    = bus.hReady;
        w_xfer       = bus.a_valid & bus.hReady;
        w_xfer_src   = 1'b0;
        w_xfer_data  = bus.a_data;
        w_xfer_flags = bus.a_flags;
        if (w_xfer && bus.a_flags[5]) begin
          w_push      = 1'b1;
          w_rr_nxt    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      OWN_B: begin
        w_b_ready    = bus.hReady;
        w_xfer       = bus.b_valid & bus.hReady;
        w_xfer_src   = 1'b1;
        w_xfer_data  = bus.b_data;
        w_xfer_flags = bus.b_flags;
        if (w_xfer && bus.b_flags[5]) begin
          w_push      = 1'b1;
          w_rr_nxt    = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_data  <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      if (w_xfer) begin
        r_data  <= w_xfer_data;
        r_flags <= w_xfer_flags;
      end else begin
        r_flags <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tags   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_tags[r_wr_ptr] <= w_xfer_src;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Combinational outputs are held low while reset is asserted.
  assign w_drop          = ~rst & (w_stray | (bus.hValid & w_empty));
  assign bus.a_ready     = ~rst & w_a_ready;
  assign bus.b_ready     = ~rst & w_b_ready;
  assign bus.drop        = w_drop;
  assign bus.data        = r_data;
  assign bus.sa          = r_flags[0];
  assign bus.da          = r_flags[1];
  assign bus.sp_dp       = r_flags[2];
  assign bus.prot        = r_flags[3];
  assign bus.soh         = r_flags[4];
  assign bus.eoh         = r_flags[5];
  assign bus.res_src     = ~w_empty & r_tags[r_rd_ptr];
  assign bus.res_src_vld = ~w_empty;
  assign bus.tag_full    = w_full;
  assign o_dbg_state     = r_state;

`ifdef HDR_ARB_STATS_EN
  logic [15:0] r_a_hdr_cnt;
  logic [15:0] r_b_hdr_cnt;
  logic [7:0]  r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_hdr_cnt <= '0;
      r_b_hdr_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_push && !w_xfer_src) r_a_hdr_cnt <= r_a_hdr_cnt + 16'd1;
      if (w_push && w_xfer_src)  r_b_hdr_cnt <= r_b_hdr_cnt + 16'd1;
      if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign bus.a_hdr_cnt = r_a_hdr_cnt;
  assign bus.b_hdr_cnt = r_b_hdr_cnt;
  assign bus.drop_cnt  = r_drop_cnt;
`endif

endmodule
